// File: rtl/slot_dispatch_if.sv
// Bundle of the slot dispatcher's request side and its single-entry output side.
// The master drives slot index, requests, payload and downstream ready; the slave answers.
interface slot_dispatch_if;
  logic [2:0]  count;
  logic [7:0]  req;
  logic [63:0] data_in;
  logic        out_ready;
  logic [7:0]  grant;
  logic [7:0]  out_data;
  logic [2:0]  out_slot;
  logic        out_valid;
  logic [7:0]  miss_cnt;

  modport master (
    output count, req, data_in, out_ready,
    input  grant, out_data, out_slot, out_valid, miss_cnt
  );

  modport slave (
    input  count, req, data_in, out_ready,
    output grant, out_data, out_slot, out_valid, miss_cnt
  );
endinterface

// File: rtl/slot_dispatch.sv
// Services at most one request per slot visit into a one-entry output buffer,
// pulsing a one-hot grant and counting visits that end with a request left unserved.
module slot_dispatch (
  input logic         clk,
  input logic         rst,
  slot_dispatch_if.slave sd
);

  logic [2:0] count_q,     count_d;
  logic       first_q,     first_d;
  logic       served_q,    served_d;
  logic [7:0] out_data_q,  out_data_d;
  logic [2:0] out_slot_q,  out_slot_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] grant_q,     grant_d;
  logic [7:0] miss_cnt_q,  miss_cnt_d;

  logic [7:0][7:0] lanes;
  logic            slot_change;
  logic            new_visit;
  logic            can_load;
  logic            service;
  logic            transfer;

  assign lanes       = sd.data_in;
  assign slot_change = (sd.count != count_q);
  assign new_visit   = first_q | slot_change;
  assign can_load    = ~out_valid_q | sd.out_ready;
  assign service     = sd.req[sd.count] & can_load & (new_visit | ~served_q);
  assign transfer    = out_valid_q & sd.out_ready;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
    count_d     = sd.count;
    first_d     = 1'b0;
    served_d    = new_visit ? 1'b0 : served_q;
    out_data_d  = out_data_q;
    out_slot_d  = out_slot_q;
    out_valid_d = out_valid_q;
    grant_d     = 8'h00;
    miss_cnt_d  = miss_cnt_q;

    if (transfer) out_valid_d = 1'b0;

    // A load overrides the drain, so a simultaneous transfer leaves no bubble.
    if (service) begin
      served_d    = 1'b1;
      out_data_d  = lanes[sd.count];
      out_slot_d  = sd.count;
      out_valid_d = 1'b1;
      grant_d     = 8'h01 << sd.count;
    end

    if (slot_change && sd.req[count_q] && !served_q && miss_cnt_q != 8'hFF)
      miss_cnt_d = miss_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= 3'd0;
      first_q     <= 1'b1;
      served_q    <= 1'b0;
      out_data_q  <= 8'h00;
      out_slot_q  <= 3'd0;
      out_valid_q <= 1'b0;
      grant_q     <= 8'h00;
      miss_cnt_q  <= 8'h00;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      count_q     <= count_d;
      first_q     <= first_d;
      served_q    <= served_d;
      out_data_q  <= out_data_d;
      out_slot_q  <= out_slot_d;
      out_valid_q <= out_valid_d;
      grant_q     <= grant_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign sd.grant     = grant_q;
  assign sd.out_data  = out_data_q;
  assign sd.out_slot  = out_slot_q;
  assign sd.out_valid = out_valid_q;
  assign sd.miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_slot_dispatch.sv
// Directed bench for slot_dispatch: a visit-level reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_slot_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  slot_dispatch_if sd_if ();

  slot_dispatch u_dut (
    .clk (clk),
    .rst (rst),
    .sd  (sd_if)
  );

  localparam logic [63:0] DATA_SEQ = 64'h1716151413121110;

  typedef struct {
    logic [7:0] data;
    logic [2:0] slot;
  } entry_t;

  // Reference model: tracks the current visit, whether it was serviced, and the buffer as a queue.
  entry_t     m_buf[$];
  int         m_prev;
  bit         m_first;
  bit         m_visit_served;
  logic [7:0] m_grant;
  int         m_miss;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_buf.delete();
      m_prev         = 0;
      m_first        = 1'b1;
      m_visit_served = 1'b0;
      m_grant        = 8'h00;
      m_miss         = 0;
    end else begin
      int  c;
      bit  changed;
      bit  room;
      bit  take;
      c       = int'(sd_if.count);
      changed = (c != m_prev);
      if (changed && sd_if.req[m_prev] && !m_visit_served && m_miss < 255) m_miss++;
      if (m_first || changed) m_visit_served = 1'b0;
      room = (m_buf.size() == 0) || sd_if.out_ready;
      take = sd_if.req[c] && room && !m_visit_served;
      if (m_buf.size() > 0 && sd_if.out_ready) void'(m_buf.pop_front());
      if (take) begin
        m_buf.push_back('{data: sd_if.data_in[c*8 +: 8], slot: 3'(c)});
        m_visit_served = 1'b1;
      end
      m_grant = take ? (8'h01 << c) : 8'h00;
      m_prev  = c;
      m_first = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("cmp_grant", 64'(sd_if.grant), 64'(m_grant));
    check("cmp_valid", 64'(sd_if.out_valid), 64'(m_buf.size() != 0));
    check("cmp_miss", 64'(sd_if.miss_cnt), 64'(m_miss));
    if (m_buf.size() != 0) begin
      check("cmp_data", 64'(sd_if.out_data), 64'(m_buf[0].data));
      check("cmp_slot", 64'(sd_if.out_slot), 64'(m_buf[0].slot));
    end
  end

  // Applies one cycle of inputs at a falling edge and returns at the next falling edge.
  task automatic cyc(input logic [2:0] c, input logic [7:0] r, input logic [63:0] d, input logic rdy);
    sd_if.count     = c;
    sd_if.req       = r;
    sd_if.data_in   = d;
    sd_if.out_ready = rdy;
    @(negedge clk);
  endtask

  initial begin
    sd_if.count     = 3'd0;
    sd_if.req       = 8'h00;
    sd_if.data_in   = 64'h0;
    sd_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", 64'(sd_if.grant), 64'h00);
    check("rst_valid", 64'(sd_if.out_valid), 64'h0);
    check("rst_data",  64'(sd_if.out_data), 64'h00);
    check("rst_miss",  64'(sd_if.miss_cnt), 64'h00);
    rst = 1'b0;

    // Single slot held: one grant, then silence for the rest of the visit.
    cyc(3'd3, 8'h08, 64'h0000_0000_A500_0000, 1'b1);
    check("hold_grant", 64'(sd_if.grant), 64'h08);
    check("hold_data",  64'(sd_if.out_data), 64'hA5);
    check("hold_slot",  64'(sd_if.out_slot), 64'd3);
    check("hold_valid", 64'(sd_if.out_valid), 64'h1);
    cyc(3'd3, 8'h08, 64'h0000_0000_A500_0000, 1'b1);
    check("hold_no_regrant", 64'(sd_if.grant), 64'h00);
    cyc(3'd3, 8'h08, 64'h0000_0000_A500_0000, 1'b1);
    check("hold_no_regrant2", 64'(sd_if.grant), 64'h00);

    // Sweep all slots back to back with full requests.
    for (int i = 0; i < 8; i++) begin
      cyc(3'(i), 8'hFF, DATA_SEQ, 1'b1);
      check("sweep_grant", 64'(sd_if.grant), 64'(8'h01 << i));
      check("sweep_valid", 64'(sd_if.out_valid), 64'h1);
      check("sweep_data",  64'(sd_if.out_data), 64'(8'h10 + i));
    end
    check("sweep_miss", 64'(sd_if.miss_cnt), 64'h00);

    // Blocked buffer: slot 5 visit ends unserved.
    cyc(3'd5, 8'h20, DATA_SEQ, 1'b0);
    check("blk_grant5", 64'(sd_if.grant), 64'h00);
    cyc(3'd6, 8'h20, DATA_SEQ, 1'b0);
    check("blk_grant6", 64'(sd_if.grant), 64'h00);
    check("blk_miss",   64'(sd_if.miss_cnt), 64'h01);
    check("blk_data",   64'(sd_if.out_data), 64'h17);
    check("blk_slot",   64'(sd_if.out_slot), 64'd7);

    // Late service inside a slot-2 visit is not a miss.
    cyc(3'd2, 8'h04, DATA_SEQ, 1'b0);
    cyc(3'd2, 8'h04, DATA_SEQ, 1'b0);
    check("late_wait", 64'(sd_if.grant), 64'h00);
    cyc(3'd2, 8'h04, DATA_SEQ, 1'b1);
    check("late_grant", 64'(sd_if.grant), 64'h04);
    check("late_data",  64'(sd_if.out_data), 64'h12);
    cyc(3'd3, 8'h00, DATA_SEQ, 1'b1);
    check("late_miss",  64'(sd_if.miss_cnt), 64'h01);
    check("late_drain", 64'(sd_if.out_valid), 64'h0);

    // Saturation: fill the buffer, then alternate slots 0/1 with the buffer stuck.
    cyc(3'd1, 8'h02, DATA_SEQ, 1'b0);
    check("sat_fill", 64'(sd_if.grant), 64'h02);
    for (int i = 0; i < 302; i++)
      cyc((i % 2 == 0) ? 3'd0 : 3'd1, 8'h03, DATA_SEQ, 1'b0);
    check("sat_miss",  64'(sd_if.miss_cnt), 64'hFF);
    check("sat_valid", 64'(sd_if.out_valid), 64'h1);

    // Mid-operation reset with an entry buffered.
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", 64'(sd_if.out_valid), 64'h0);
    check("mrst_miss",  64'(sd_if.miss_cnt), 64'h00);
    check("mrst_grant", 64'(sd_if.grant), 64'h00);
    check("mrst_data",  64'(sd_if.out_data), 64'h00);
    @(negedge clk);
    rst = 1'b0;
    cyc(3'd4, 8'h10, DATA_SEQ, 1'b1);
    check("post_grant", 64'(sd_if.grant), 64'h10);
    check("post_data",  64'(sd_if.out_data), 64'h14);
    check("post_slot",  64'(sd_if.out_slot), 64'd4);
    cyc(3'd4, 8'h10, DATA_SEQ, 1'b1);
    check("post_once", 64'(sd_if.grant), 64'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
